// File: rtl/idma_burst_gen.sv
// Burst generator for the iDMA address path: splits a 2-D transfer into bursts of at
// most MAX_BURST 32-byte beats, caps outstanding bursts, and pulses done at the end.
module idma_burst_gen #(
   parameter int MAX_BURST = 16,
   parameter int MAX_OUTST = 4,
   parameter int OUTW      = 3
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        cfg_start,
   input  logic [31:0] cfg_base_addr,
   input  logic [15:0] cfg_row_beats,
   input  logic [15:0] cfg_rows,
   input  logic [31:0] cfg_stride,
   output logic        dma_trans_burst_avalid,
   output logic [31:0] dma_trans_burst_addr,
   output logic [3:0]  dma_trans_burst_len,
   input  logic        dma_xaddr_burst_ok,
   input  logic        burst_data_done,
   output logic        busy,
   output logic        done,
   output logic        err_underflow
);

   // state  | meaning
   // IDLE   | waiting for cfg_start
   // ISSUE  | presenting bursts, advancing on dma_xaddr_burst_ok
   // DRAIN  | all bursts issued, waiting for outstanding data to complete
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q;
   logic [15:0]     row_beats_q;
   logic [15:0]     rows_q;
   logic [31:0]     stride_q;
   logic [31:0]     row_addr_q;
   logic [15:0]     beat_off_q;
   logic [15:0]     row_cnt_q;
   logic            avalid_hold_q;
   logic [OUTW-1:0] outst_q;
   logic            err_q;

   logic [15:0] remain;
   logic [3:0]  len_c;
   logic [16:0] off_next;
   logic        row_end;
   logic        last_row;
   logic        below_cap;
   logic        avalid_c;
   logic        accept;
   logic        cfg_accept;

   assign remain    = row_beats_q - beat_off_q;
   assign len_c     = (remain >= 16'(MAX_BURST)) ? 4'(MAX_BURST - 1) : (remain[3:0] - 4'd1);
   assign off_next  = {1'b0, beat_off_q} + {13'd0, len_c} + 17'd1;
   assign row_end   = (off_next == {1'b0, row_beats_q});
   assign last_row  = ((row_cnt_q + 16'd1) == rows_q);
   assign below_cap = (outst_q < OUTW'(MAX_OUTST));
   // Once raised, valid is held until accepted even if the cap is reached meanwhile.
   assign avalid_c  = (state_q == S_ISSUE) && (below_cap || avalid_hold_q);
   assign accept    = avalid_c && dma_xaddr_burst_ok;
   assign cfg_accept = (state_q == S_IDLE) && cfg_start;

   assign dma_trans_burst_avalid = avalid_c;
   assign dma_trans_burst_addr   = (state_q == S_ISSUE) ?
                                   (row_addr_q + {11'd0, beat_off_q, 5'd0}) : 32'd0;
   assign dma_trans_burst_len    = (state_q == S_ISSUE) ? len_c : 4'd0;
   assign busy                   = (state_q != S_IDLE);
   assign done                   = (state_q == S_DRAIN) && (outst_q == '0);
   assign err_underflow          = err_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= S_IDLE;
         row_beats_q   <= 16'd0;
         rows_q        <= 16'd0;
         stride_q      <= 32'd0;
         row_addr_q    <= 32'd0;
         beat_off_q    <= 16'd0;
         row_cnt_q     <= 16'd0;
         avalid_hold_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               avalid_hold_q <= 1'b0;
               if (cfg_start) begin
                  row_beats_q <= cfg_row_beats;
                  rows_q      <= cfg_rows;
                  stride_q    <= cfg_stride & ~32'h1F;
                  row_addr_q  <= cfg_base_addr & ~32'h1F;
                  beat_off_q  <= 16'd0;
                  row_cnt_q   <= 16'd0;
                  if ((cfg_rows == 16'd0) || (cfg_row_beats == 16'd0))
                     state_q <= S_DRAIN;
                  else
                     state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               avalid_hold_q <= avalid_c && !dma_xaddr_burst_ok;
               if (accept) begin
                  if (row_end) begin
                     beat_off_q <= 16'd0;
                     row_addr_q <= row_addr_q + stride_q;
                     row_cnt_q  <= row_cnt_q + 16'd1;
                     if (last_row)
                        state_q <= S_DRAIN;
                  end else begin
                     beat_off_q <= off_next[15:0];
                  end
               end
            end
            S_DRAIN: begin
               avalid_hold_q <= 1'b0;
               if (outst_q == '0)
                  state_q <= S_IDLE;
            end
            default: begin
               avalid_hold_q <= 1'b0;
               state_q       <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (cfg_accept)
            err_q <= 1'b0;
         if (accept && !burst_data_done) begin
            if (outst_q != OUTW'(MAX_OUTST))
               outst_q <= outst_q + 1'b1;
         end else if (burst_data_done && !accept) begin
            // A completion with nothing outstanding is flagged, never wrapped.
            if (outst_q == '0)
               err_q <= 1'b1;
            else
               outst_q <= outst_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_idma_burst_gen.sv
// Scoreboard bench for idma_burst_gen: expected bursts are queued from a reference
// split of each programmed transfer and popped as the DUT presents them.
module tb_idma_burst_gen;

   localparam int MAXO = 2;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [15:0] cfg_row_beats = '0;
   logic [15:0] cfg_rows = '0;
   logic [31:0] cfg_stride = '0;
   logic        dma_trans_burst_avalid;
   logic [31:0] dma_trans_burst_addr;
   logic [3:0]  dma_trans_burst_len;
   logic        dma_xaddr_burst_ok = 1'b0;
   logic        burst_data_done = 1'b0;
   logic        busy;
   logic        done;
   logic        err_underflow;

   idma_burst_gen #(.MAX_BURST(16), .MAX_OUTST(MAXO), .OUTW(3)) u_dut (
      .aclk                   (aclk),
      .aresetn                (aresetn),
      .cfg_start              (cfg_start),
      .cfg_base_addr          (cfg_base_addr),
      .cfg_row_beats          (cfg_row_beats),
      .cfg_rows               (cfg_rows),
      .cfg_stride             (cfg_stride),
      .dma_trans_burst_avalid (dma_trans_burst_avalid),
      .dma_trans_burst_addr   (dma_trans_burst_addr),
      .dma_trans_burst_len    (dma_trans_burst_len),
      .dma_xaddr_burst_ok     (dma_xaddr_burst_ok),
      .burst_data_done        (burst_data_done),
      .busy                   (busy),
      .done                   (done),
      .err_underflow          (err_underflow)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad = 0;
   logic [35:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_model(input logic [31:0] base, input logic [15:0] rb,
                             input logic [15:0] rows, input logic [31:0] stride);
      logic [31:0] row_addr;
      logic [31:0] st;
      int off;
      int n;
      row_addr = base & ~32'h1F;
      st = stride & ~32'h1F;
      for (int r = 0; r < int'(rows); r++) begin
         off = 0;
         while (off < int'(rb)) begin
            n = (int'(rb) - off > 16) ? 16 : int'(rb) - off;
            exp_q.push_back({row_addr + 32'(off * 32), 4'(n - 1)});
            off += n;
         end
         row_addr = row_addr + st;
      end
   endtask

   task automatic run_xfer(input logic [31:0] base, input logic [15:0] rb, input logic [15:0] rows,
                           input logic [31:0] stride, input int ok_pct, input int dd_pct,
                           input int stall);
      int pending;
      int n;
      int stall_left;
      bit got_done;
      bit ok;
      bit dd;
      logic [35:0] e;
      pending = 0;
      n = 0;
      stall_left = stall;
      got_done = 0;
      exp_q.delete();
      push_model(base, rb, rows, stride);
      cfg_base_addr = base;
      cfg_row_beats = rb;
      cfg_rows = rows;
      cfg_stride = stride;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("busy_latency", busy, 1);
      check("err_cleared", err_underflow, 0);
      while (!got_done && n < 3000) begin
         ok = 0;
         dd = 0;
         check("avalid", dma_trans_burst_avalid, (exp_q.size() > 0 && pending < MAXO));
         check("done", done, (exp_q.size() == 0 && pending == 0));
         if (done) begin
            got_done = 1;
         end else begin
            if (dma_trans_burst_avalid && exp_q.size() > 0) begin
               e = exp_q[0];
               check("addr", dma_trans_burst_addr, e[35:4]);
               check("len", dma_trans_burst_len, e[3:0]);
               if (stall_left > 0)
                  stall_left--;
               else if (int'($urandom_range(99)) < ok_pct) begin
                  ok = 1;
                  void'(exp_q.pop_front());
               end
            end
            if (pending > 0 && int'($urandom_range(99)) < dd_pct)
               dd = 1;
         end
         dma_xaddr_burst_ok = ok;
         burst_data_done = dd;
         tick();
         dma_xaddr_burst_ok = 1'b0;
         burst_data_done = 1'b0;
         pending += int'(ok) - int'(dd);
         n++;
      end
      check("done_timeout", got_done, 1);
      check("idle_after_done", busy, 0);
      check("no_underflow", err_underflow, 0);
   endtask

   initial begin
      #2;
      check("rst_avalid", dma_trans_burst_avalid, 0);
      check("rst_addr", dma_trans_burst_addr, 0);
      check("rst_len", dma_trans_burst_len, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_underflow, 0);
      tick();
      aresetn = 1'b1;
      tick();

      // single long row: (0x1000,15),(0x1200,15),(0x1400,7)
      run_xfer(32'h1000, 16'd40, 16'd1, 32'd0, 100, 100, 0);
      // three short strided rows
      run_xfer(32'h2000, 16'd4, 16'd3, 32'h400, 100, 60, 0);
      // cap pressure: slow completions, then ok and completion together
      run_xfer(32'h0, 16'd4, 16'd6, 32'h80, 100, 15, 0);
      run_xfer(32'h0, 16'd4, 16'd6, 32'h80, 100, 100, 0);
      // held request: ok low for 5 cycles, addr/len/avalid must hold
      run_xfer(32'h0FE0, 16'd16, 16'd1, 32'd0, 100, 50, 5);
      // unaligned base/stride, stride 0, 32-bit wrap, random handshakes
      run_xfer(32'h0000_301F, 16'd17, 16'd2, 32'd0, 70, 40, 0);
      run_xfer(32'hFFFF_FFC0, 16'd3, 16'd3, 32'h0000_003F, 60, 50, 2);
      run_xfer(32'h0001_0000, 16'd33, 16'd3, 32'h0000_0800, 50, 30, 0);
      // zero-burst transfers
      run_xfer(32'h3000, 16'd8, 16'd0, 32'd0, 100, 100, 0);
      run_xfer(32'h3000, 16'd0, 16'd3, 32'd0, 100, 100, 0);

      // completion while idle sets the sticky error
      burst_data_done = 1'b1;
      tick();
      burst_data_done = 1'b0;
      check("underflow_set", err_underflow, 1);
      tick();
      check("underflow_sticky", err_underflow, 1);
      check("underflow_idle", busy, 0);

      // reset mid-row, then restart from base
      cfg_base_addr = 32'h5000;
      cfg_row_beats = 16'd40;
      cfg_rows = 16'd2;
      cfg_stride = 32'h1000;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("mid_avalid", dma_trans_burst_avalid, 1);
      check("mid_addr0", dma_trans_burst_addr, 32'h5000);
      dma_xaddr_burst_ok = 1'b1;
      tick();
      dma_xaddr_burst_ok = 1'b0;
      check("mid_addr1", dma_trans_burst_addr, 32'h5200);
      #2;
      aresetn = 1'b0;
      #1;
      check("arst_avalid", dma_trans_burst_avalid, 0);
      check("arst_addr", dma_trans_burst_addr, 0);
      check("arst_len", dma_trans_burst_len, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err", err_underflow, 0);
      tick();
      aresetn = 1'b1;
      tick();
      run_xfer(32'h5000, 16'd40, 16'd2, 32'h1000, 80, 50, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
